// File: rtl/prod_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : prod_accumulator
//  Description : Consumes products from the 8-bit sequential multiplier,
//                sums BATCH of them into an ACC_W-bit running total and
//                queues completed totals in a 2-entry output buffer that is
//                drained through a valid/ready handshake.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    Clk        in   rising-edge clock
//    Reset_n    in   asynchronous active-low reset
//    Prod_In    in   PROD_W  product from the multiplier
//    Prod_Done  in   one-cycle strobe, Prod_In valid this cycle
//    Clear      in   synchronous flush of sum, count, flags and buffer
//    Acc_Out    out  ACC_W   oldest buffered result
//    Out_Valid  out  buffer non-empty
//    Out_Ready  in   consumer takes Acc_Out at this edge
//    Count      out  8       products accumulated in the current batch
//    Overflow   out  sticky, an addition carried out of ACC_W
//    Drop       out  sticky, a completed result was lost to a full buffer
//    Hold       out  buffer full, upstream must not issue Load
// ============================================================================
module prod_accumulator #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int BATCH  = 4
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [PROD_W-1:0] Prod_In,
    input  logic              Prod_Done,
    input  logic              Clear,
    output logic [ACC_W-1:0]  Acc_Out,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [7:0]        Count,
    output logic              Overflow,
    output logic              Drop,
    output logic              Hold
);

    localparam logic [7:0] C_LAST = 8'(BATCH - 1);

    typedef enum logic [0:0] {
        ACC_IDLE = 1'b0,
        ACC_RUN  = 1'b1
    } acc_state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    acc_state_t        state_q, state_d;
    logic [ACC_W-1:0]  sum_q, sum_d;
    logic [7:0]        count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              drop_q, drop_d;
    logic              hold_q, hold_d;
    logic [1:0]        entries_q, entries_d;
    // Buffer is kept as explicit head/tail registers so the head drives
    // Acc_Out directly and simply keeps its old value when emptied.
    logic [ACC_W-1:0]  head_q, head_d;
    logic [ACC_W-1:0]  tail_q, tail_d;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic              w_accept;
    logic              w_batch_done;
    logic              w_pop;
    logic [ACC_W:0]    w_sum_ext;

    assign w_accept     = Prod_Done & ~Clear;
    assign w_batch_done = w_accept & (count_q == C_LAST);
    // Out_Valid is 0 when empty, so a pop request on an empty buffer is
    // naturally ignored.
    assign w_pop        = (entries_q != 2'd0) & Out_Ready & ~Clear;
    // One extra bit on top of the accumulator captures the carry out.
    assign w_sum_ext    = {1'b0, sum_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, Prod_In};

    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        drop_d    = drop_q;
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;

        if (Clear) begin
            // Head is left alone: Acc_Out keeps its stale value while
            // Out_Valid is low.
            state_d   = ACC_IDLE;
            sum_d     = '0;
            count_d   = '0;
            ovf_d     = 1'b0;
            drop_d    = 1'b0;
            entries_d = 2'd0;
        end else begin
            // Accumulator FSM
            case (state_q)
                ACC_IDLE: if (w_accept) state_d = w_batch_done ? ACC_IDLE : ACC_RUN;
                ACC_RUN:  if (w_batch_done) state_d = ACC_IDLE;
                default:  state_d = ACC_IDLE;
            endcase

            if (w_accept) begin
                if (w_sum_ext[ACC_W]) begin
                    ovf_d = 1'b1;
                end
                if (w_batch_done) begin
                    sum_d   = '0;
                    count_d = '0;
                end else begin
                    sum_d   = w_sum_ext[ACC_W-1:0];
                    count_d = count_q + 8'd1;
                end
            end

            // Output buffer: push is the completed sum, pop is the handshake.
            case (entries_q)
                2'd0: begin
                    if (w_batch_done) begin
                        head_d    = w_sum_ext[ACC_W-1:0];
                        entries_d = 2'd1;
                    end
                end
                2'd1: begin
                    if (w_batch_done && w_pop) begin
                        head_d = w_sum_ext[ACC_W-1:0];
                    end else if (w_batch_done) begin
                        tail_d    = w_sum_ext[ACC_W-1:0];
                        entries_d = 2'd2;
                    end else if (w_pop) begin
                        entries_d = 2'd0;
                    end
                end
                default: begin
                    if (w_batch_done && w_pop) begin
                        // Simultaneous pop frees a slot, so the push succeeds.
                        head_d = tail_q;
                        tail_d = w_sum_ext[ACC_W-1:0];
                    end else if (w_batch_done) begin
                        drop_d = 1'b1;
                    end else if (w_pop) begin
                        head_d    = tail_q;
                        entries_d = 2'd1;
                    end
                end
            endcase
        end

        hold_d = (entries_d == 2'd2);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ACC_IDLE;
            sum_q     <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            drop_q    <= 1'b0;
            hold_q    <= 1'b0;
            entries_q <= 2'd0;
            head_q    <= '0;
            tail_q    <= '0;
        end else begin
            state_q   <= state_d;
            sum_q     <= sum_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            drop_q    <= drop_d;
            hold_q    <= hold_d;
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
        end
    end

    assign Acc_Out   = head_q;
    assign Out_Valid = (entries_q != 2'd0);
    assign Count     = count_q;
    assign Overflow  = ovf_q;
    assign Drop      = drop_q;
    assign Hold      = hold_q;

endmodule
`default_nettype wire

// File: doc/prod_accumulator.md
Name: prod_accumulator

Overview:
Downstream consumer of the 8-bit sequential multiplier. Captures each 16-bit product on the multiplier's one-cycle Done pulse and sums BATCH products into an ACC_W-bit running total. Completed totals go into a 2-entry output buffer, read through a valid/ready handshake. Hold back-pressures the operand source so it does not issue Load while the buffer is full.

Parameters:
PROD_W, 16, product width; matches the multiplier's O port
ACC_W, 24, accumulator and result width (must be >= PROD_W+1)
BATCH, 4, products summed per result (1..255)

Ports:
Clk  input  1  rising-edge clock
Reset_n  input  1  asynchronous, active-low reset
Prod_In  input  PROD_W  product from multiplier O
Prod_Done  input  1  one-cycle strobe; Prod_In valid this cycle
Clear  input  1  synchronous flush of accumulator, count, flags and buffer
Acc_Out  output  ACC_W  buffer head value
Out_Valid  output  1  buffer non-empty
Out_Ready  input  1  consumer accepts Acc_Out this edge
Count  output  8  products accumulated in the current batch
Overflow  output  1  sticky; an addition carried out of ACC_W
Drop  output  1  sticky; a completed result was discarded because the buffer was full
Hold  output  1  buffer full; upstream must not assert Load

Behaviour:
- Interface is decided: one clock, Clk. Reset_n is asynchronous and active-low.
- Reset (Reset_n=0, any time, including mid-batch): sum=0, Count=0, buffer empty, Acc_Out=0, Out_Valid=0, Overflow=0, Drop=0, Hold=0, FSM in ACC_IDLE.
- Accumulator FSM:
  - ACC_IDLE (Count==0) goes to ACC_RUN on an accepted Prod_Done.
  - ACC_RUN returns to ACC_IDLE when the BATCH-th product is accepted.
- Accept rule: Prod_Done=1 and Clear=0 at a rising edge.
- On accept:
  - sum <= sum + zero-extended Prod_In, modulo 2^ACC_W; Count <= Count+1.
  - Carry out of bit ACC_W-1 sets Overflow; it stays set until Clear or reset.
- Batch completion: when the accepted product makes Count reach BATCH:
  - sum+Prod_In is pushed to the buffer on the same edge.
  - sum <= 0 and Count <= 0 on the same edge.
  - Result appears on Acc_Out with Out_Valid=1 on the following cycle, if the buffer was empty.
- Buffer: 2-entry FIFO. Pop occurs when Out_Valid and Out_Ready are both 1 at an edge.
  - Acc_Out is the oldest entry and is stable while Out_Valid=1 and Out_Ready=0.
- Hold = (entries==2), registered.
- Full and push with no pop: the result is discarded, Drop is set, and the accumulator still clears.
- Full with simultaneous pop and push: the push succeeds, entries stay 2, and Drop is not set.
- Empty with simultaneous push and pop: the pop is ignored (Out_Valid was 0).
- Clear has priority over Prod_Done and Out_Ready in the same cycle:
  - All state returns to reset values except Acc_Out, which holds its stale value while Out_Valid=0.
  - A product presented with Clear is lost.
- Prod_Done asserted on consecutive cycles: each cycle is a separate accept (no internal throttling).
- Count never exceeds BATCH-1 when observed.
- All arithmetic is unsigned. Result latency from accepting the last product to Out_Valid is 1 cycle.

Test Plan:
- Basic batch: BATCH=4; Prod_Done pulses with 100, 200, 300, 400 -> Acc_Out=1000 and Out_Valid=1 one cycle after the 4th pulse; Count=0; Overflow=0; pop with Out_Ready=1 -> Out_Valid=0.
- Overflow wrap: ACC_W=17; four products of 0xFFFF -> Overflow=1 after the third product (sum 0x0FFFD); Acc_Out=0x1FFFC.
- Back-pressure: Out_Ready=0; three batches of 1,1,1,1 -> two entries of 4, Hold=1 after the second push, Drop=1 after the third; then Out_Ready=1 pops 4, 4, then Out_Valid=0 and Hold=0.
- Full with simultaneous pop/push: buffer full; Out_Ready=1 on the completing edge -> Drop=0, entries remain 2, and the new result is second in line.
- Clear/reset mid-batch: after 2 products of 50, Clear with a Prod_Done of 70 -> Count=0 and the 70 is ignored; next 4×10 -> Acc_Out=40. Repeat with Reset_n pulsed low between clock edges -> all outputs zero immediately.
- End-to-end: multiplier a=10, b=10, run four times with Done driving Prod_Done -> Acc_Out=400.
